mem_port_arbiter: RTL and testbench

- Arbitrates the CPU instruction-fetch and data-access sram-like request channels onto a single downstream memory port.
- Sits after the fixed-map address translation, so all addresses are physical.
- Allows one outstanding transaction, with data-side priority and a starvation guard for fetch.
- Carries the data-side uncached attribute to the memory side.

---
 rtl/cpu_bus_pkg.sv | 27 ++
 rtl/mem_port_arbiter_if.sv | 20 ++
 rtl/mem_port_arbiter_starve_guard.sv | 25 ++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: address/data widths, transfer size codes,
// arbiter FSM encoding and the downstream command bundle.
package cpu_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_I = 2'd1,
    ST_WAIT_D = 2'd2
  } arb_state_t;

  // Everything the memory port needs besides the req strobe itself.
  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              uncached;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// sram-like request channel. The requester uses the master modport,
// the responder the slave modport.
interface mem_port_arbiter_if;
  import cpu_bus_pkg::*;

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              uncached;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wr, size, addr, wdata, uncached,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, addr, wdata, uncached,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_port_arbiter_starve_guard.sv
// Fetch starvation guard: counts data grants made while a fetch waits and
// forces the next grant to fetch once STARVE_LIMIT of them have happened.
module starve_guard #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic inst_acc,
  input  logic data_acc,
  output logic force_inst
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // Fetch acceptance clears; data acceptance with a waiting fetch counts up, saturating.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                            starve_cnt <= '0;
    else if (inst_acc)                                      starve_cnt <= '0;
    else if (data_acc && inst_req && starve_cnt != LIMIT)   starve_cnt <= starve_cnt + 4'd1;
  end

  assign force_inst = inst_req && (starve_cnt == LIMIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one downstream sram-like port, one transaction
// outstanding, data priority with a fetch starvation guard.
// Optional build macro MEM_ARB_PERF_CNT_EN adds grant/conflict counters.
module mem_port_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  mem_port_arbiter_if.slave     inst_bus,
  mem_port_arbiter_if.slave     data_bus,
  mem_port_arbiter_if.master    mem_bus
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_inst_grants,
  output logic [31:0]           perf_data_grants,
  output logic [31:0]           perf_conflict_cycles
`endif
);
  arb_state_t state, state_nxt;
  mem_cmd_t   cmd_d, cmd_i, cmd;
  logic       gnt_d, gnt_i, inst_acc, data_acc, force_inst;

  // Fetch channel carries only an address; its other request fields are ignored.
  logic unused_inst;
  assign unused_inst = ^{inst_bus.wr, inst_bus.size, inst_bus.wdata, inst_bus.uncached};

  assign cmd_d = '{wr: data_bus.wr, size: data_bus.size, addr: data_bus.addr,
                   wdata: data_bus.wdata, uncached: data_bus.uncached};
  assign cmd_i = '{wr: 1'b0, size: SZ_WORD, addr: inst_bus.addr,
                   wdata: '0, uncached: 1'b0};

  starve_guard #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_guard (
    .clk        (clk),
    .resetn     (resetn),
    .inst_req   (inst_bus.req),
    .inst_acc   (inst_acc),
    .data_acc   (data_acc),
    .force_inst (force_inst)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Grant selection in IDLE, acceptance and return to IDLE on the response.
  always_comb begin
    state_nxt = state;
    gnt_d     = 1'b0;
    gnt_i     = 1'b0;
    inst_acc  = 1'b0;
    data_acc  = 1'b0;
    cmd       = '0;
    case (state)
      ST_IDLE: begin
        gnt_d    = data_bus.req && !force_inst;
        gnt_i    = !gnt_d && inst_bus.req;
        if (gnt_d)      cmd = cmd_d;
        else if (gnt_i) cmd = cmd_i;
        data_acc = gnt_d && mem_bus.addr_ok;
        inst_acc = gnt_i && mem_bus.addr_ok;
        if (data_acc)      state_nxt = ST_WAIT_D;
        else if (inst_acc) state_nxt = ST_WAIT_I;
      end
      ST_WAIT_I, ST_WAIT_D: begin
        // No new accept in the response cycle: one bubble between transactions.
        if (mem_bus.data_ok) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_bus.req      = gnt_d | gnt_i;
  assign mem_bus.wr       = cmd.wr;
  assign mem_bus.size     = cmd.size;
  assign mem_bus.addr     = cmd.addr;
  assign mem_bus.wdata    = cmd.wdata;
  assign mem_bus.uncached = cmd.uncached;

  assign inst_bus.addr_ok = inst_acc;
  assign data_bus.addr_ok = data_acc;
  assign inst_bus.data_ok = (state == ST_WAIT_I) && mem_bus.data_ok;
  assign data_bus.data_ok = (state == ST_WAIT_D) && mem_bus.data_ok;
  assign inst_bus.rdata   = mem_bus.rdata;
  assign data_bus.rdata   = mem_bus.rdata;

`ifdef MEM_ARB_PERF_CNT_EN
  // Free-running grant and conflict counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_inst_grants     <= '0;
      perf_data_grants     <= '0;
      perf_conflict_cycles <= '0;
    end else begin
      if (inst_acc) perf_inst_grants <= perf_inst_grants + 32'd1;
      if (data_acc) perf_data_grants <= perf_data_grants + 32'd1;
      if (state == ST_IDLE && inst_bus.req && data_bus.req)
        perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
  import cpu_bus_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_port_arbiter_if inst_if();
  mem_port_arbiter_if data_if();
  mem_port_arbiter_if mem_if();

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_i, perf_d, perf_c;
`endif

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .inst_bus (inst_if),
    .data_bus (data_if),
    .mem_bus  (mem_if)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .perf_inst_grants     (perf_i),
    .perf_data_grants     (perf_d),
    .perf_conflict_cycles (perf_c)
`endif
  );

  int checks = 0;
  int passes = 0;

  // All DUT outputs except read data, in one vector.
  function automatic logic [72:0] outs();
    return {mem_if.req, mem_if.wr, mem_if.size, mem_if.addr, mem_if.wdata, mem_if.uncached,
            inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok};
  endfunction

  task automatic idle_inputs();
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = 0; inst_if.addr = 0;
    inst_if.wdata = 0; inst_if.uncached = 0;
    data_if.req = 0; data_if.wr = 0; data_if.size = 0; data_if.addr = 0;
    data_if.wdata = 0; data_if.uncached = 0;
    mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_reset();
    resetn = 0;
    idle_inputs();
    @(negedge clk); #1;
    checks++; if (outs() !== '0) $display("FAIL reset_outs: got %h want 0", outs()); else passes++;
    checks++; if (inst_if.rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", inst_if.rdata); else passes++;
    @(negedge clk);
    resetn = 1;
    @(negedge clk); #1;
    checks++; if (outs() !== '0) $display("FAIL post_reset_idle: got %h want 0", outs()); else passes++;
  endtask

  task automatic test_lone_fetch();
    @(negedge clk);
    inst_if.req = 1; inst_if.addr = 32'h1FC0_0000; mem_if.addr_ok = 1;
    #1;
    checks++; if ({mem_if.req, mem_if.addr, mem_if.wr} !== {1'b1, 32'h1FC0_0000, 1'b0})
      $display("FAIL fetch_drive: got %h want %h", {mem_if.req, mem_if.addr, mem_if.wr}, {1'b1, 32'h1FC0_0000, 1'b0}); else passes++;
    checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b10)
      $display("FAIL fetch_accept: got %b want 10", {inst_if.addr_ok, data_if.addr_ok}); else passes++;
    @(negedge clk);
    inst_if.req = 0; mem_if.addr_ok = 0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin mem_if.data_ok = 1; mem_if.rdata = 32'h3C08_BFAF; end
      #1;
      if (k < 3) begin
        checks++; if ({mem_if.req, inst_if.data_ok, data_if.data_ok} !== 3'b000)
          $display("FAIL fetch_wait%0d: got %b want 000", k, {mem_if.req, inst_if.data_ok, data_if.data_ok}); else passes++;
      end else begin
        checks++; if ({inst_if.data_ok, data_if.data_ok, inst_if.rdata} !== {2'b10, 32'h3C08_BFAF})
          $display("FAIL fetch_resp: got %h want %h", {inst_if.data_ok, data_if.data_ok, inst_if.rdata}, {2'b10, 32'h3C08_BFAF}); else passes++;
      end
      @(negedge clk);
    end
    mem_if.data_ok = 0; mem_if.rdata = 0;
    #1;
    checks++; if (inst_if.data_ok !== 1'b0) $display("FAIL fetch_single_pulse: got %b want 0", inst_if.data_ok); else passes++;
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    inst_if.req = 1; inst_if.addr = 32'h1FC0_0010;
    data_if.req = 1; data_if.wr = 1; data_if.size = SZ_WORD;
    data_if.addr = 32'h0000_1000; data_if.wdata = 32'hDEAD_BEEF; data_if.uncached = 0;
    mem_if.addr_ok = 1;
    #1;
    checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b01)
      $display("FAIL simul_data_first: got %b want 01", {inst_if.addr_ok, data_if.addr_ok}); else passes++;
    checks++; if ({mem_if.wr, mem_if.size, mem_if.addr, mem_if.wdata} !== {1'b1, 2'd2, 32'h0000_1000, 32'hDEAD_BEEF})
      $display("FAIL simul_data_fields: got %h want %h", {mem_if.wr, mem_if.size, mem_if.addr, mem_if.wdata},
               {1'b1, 2'd2, 32'h0000_1000, 32'hDEAD_BEEF}); else passes++;
    @(negedge clk);
    data_if.req = 0; mem_if.data_ok = 1;
    #1;
    checks++; if ({data_if.data_ok, inst_if.addr_ok, mem_if.req} !== 3'b100)
      $display("FAIL simul_bubble: got %b want 100", {data_if.data_ok, inst_if.addr_ok, mem_if.req}); else passes++;
    @(negedge clk);
    mem_if.data_ok = 0;
    #1;
    checks++; if ({inst_if.addr_ok, mem_if.addr, mem_if.wr} !== {1'b1, 32'h1FC0_0010, 1'b0})
      $display("FAIL simul_inst_next: got %h want %h", {inst_if.addr_ok, mem_if.addr, mem_if.wr}, {1'b1, 32'h1FC0_0010, 1'b0}); else passes++;
    @(negedge clk);
    inst_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1;
    #1;
    checks++; if (inst_if.data_ok !== 1'b1) $display("FAIL simul_inst_resp: got %b want 1", inst_if.data_ok); else passes++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic [5:0] seq = '0;
    int n = 0;
    @(negedge clk);
    inst_if.req = 1; inst_if.addr = 32'h1FC0_0100;
    data_if.req = 1; data_if.addr = 32'h0000_2000; data_if.size = SZ_WORD;
    mem_if.addr_ok = 1; mem_if.data_ok = 1;
    for (int c = 0; c < 30 && n < 6; c++) begin
      #1;
      if (mem_if.req && mem_if.addr_ok) begin seq[n] = inst_if.addr_ok; n++; end
      @(negedge clk);
    end
    checks++; if (n !== 6) $display("FAIL starve_grant_count: got %0d want 6", n); else passes++;
    // D D D D I D, bit index = grant order, 1 = fetch
    checks++; if (seq !== 6'b010000) $display("FAIL starve_order: got %b want 010000", seq); else passes++;
    inst_if.req = 0; data_if.req = 0;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    data_if.req = 1; data_if.wr = 0; data_if.size = SZ_HALF; data_if.addr = 32'h0000_2002;
    mem_if.addr_ok = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if ({data_if.addr_ok, mem_if.req, mem_if.addr, mem_if.size} !== {2'b01, 32'h0000_2002, 2'd1})
        $display("FAIL bp_hold%0d: got %h want %h", k, {data_if.addr_ok, mem_if.req, mem_if.addr, mem_if.size},
                 {2'b01, 32'h0000_2002, 2'd1}); else passes++;
      @(negedge clk);
    end
    mem_if.addr_ok = 1;
    #1;
    checks++; if (data_if.addr_ok !== 1'b1) $display("FAIL bp_accept: got %b want 1", data_if.addr_ok); else passes++;
    @(negedge clk); #1;
    checks++; if (data_if.addr_ok !== 1'b0) $display("FAIL bp_one_cycle: got %b want 0", data_if.addr_ok); else passes++;
    @(negedge clk);
    mem_if.data_ok = 1;
    #1;
    checks++; if ({data_if.data_ok, data_if.addr_ok} !== 2'b10)
      $display("FAIL bp_resp: got %b want 10", {data_if.data_ok, data_if.addr_ok}); else passes++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_uncached();
    @(negedge clk);
    data_if.req = 1; data_if.uncached = 1; data_if.addr = 32'h1FAF_0000; data_if.size = SZ_BYTE;
    mem_if.addr_ok = 1;
    #1;
    checks++; if ({mem_if.uncached, mem_if.size, mem_if.addr} !== {1'b1, 2'd0, 32'h1FAF_0000})
      $display("FAIL unc_data: got %h want %h", {mem_if.uncached, mem_if.size, mem_if.addr}, {1'b1, 2'd0, 32'h1FAF_0000}); else passes++;
    @(negedge clk);
    data_if.req = 0; mem_if.data_ok = 1;
    @(negedge clk);
    mem_if.data_ok = 0;
    inst_if.req = 1; inst_if.addr = 32'h1FC0_0020;
    #1;
    checks++; if ({inst_if.addr_ok, mem_if.uncached, mem_if.size} !== {1'b1, 1'b0, 2'd2})
      $display("FAIL unc_fetch_after: got %h want %h", {inst_if.addr_ok, mem_if.uncached, mem_if.size}, {1'b1, 1'b0, 2'd2}); else passes++;
    @(negedge clk);
    inst_if.req = 0; mem_if.data_ok = 1;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    data_if.req = 1; data_if.addr = 32'h0000_3000; mem_if.addr_ok = 1;
    #1;
    checks++; if (data_if.addr_ok !== 1'b1) $display("FAIL rst_mid_accept: got %b want 1", data_if.addr_ok); else passes++;
    @(negedge clk);
    resetn = 0;
    idle_inputs();
    #1;
    checks++; if (outs() !== '0) $display("FAIL rst_mid_outs: got %h want 0", outs()); else passes++;
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    mem_if.data_ok = 1; mem_if.rdata = 32'h1234_5678;
    #1;
    checks++; if ({data_if.data_ok, inst_if.data_ok, mem_if.req} !== 3'b000)
      $display("FAIL rst_mid_stray: got %b want 000", {data_if.data_ok, inst_if.data_ok, mem_if.req}); else passes++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    bit busy = 0, own_i = 0;
    int starve = 0, n_ig = 0, n_dg = 0, n_cf = 0;
    logic e_ig, e_dg;
    logic [72:0] exp_v;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_size;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      inst_if.req = ($urandom_range(0, 9) < 7); inst_if.addr = $urandom;
      data_if.req = ($urandom_range(0, 9) < 7); data_if.addr = $urandom;
      data_if.wr = 1'($urandom_range(0, 1)); data_if.size = 2'($urandom_range(0, 2));
      data_if.wdata = $urandom; data_if.uncached = 1'($urandom_range(0, 1));
      mem_if.addr_ok = ($urandom_range(0, 2) != 0);
      mem_if.data_ok = ($urandom_range(0, 2) == 0);
      mem_if.rdata = $urandom;
      #1;
      e_dg = !busy && data_if.req && !(starve >= LIMIT && inst_if.req);
      e_ig = !busy && !e_dg && inst_if.req;
      e_addr  = e_dg ? data_if.addr  : (e_ig ? inst_if.addr : 32'h0);
      e_wdata = e_dg ? data_if.wdata : 32'h0;
      e_size  = e_dg ? data_if.size  : (e_ig ? 2'd2 : 2'd0);
      exp_v = {e_ig | e_dg, e_dg & data_if.wr, e_size, e_addr, e_wdata, e_dg & data_if.uncached,
               e_ig & mem_if.addr_ok, e_dg & mem_if.addr_ok,
               busy & own_i & mem_if.data_ok, busy & !own_i & mem_if.data_ok};
      checks++; if (outs() !== exp_v) $display("FAIL rand_cyc%0d: got %h want %h", c, outs(), exp_v); else passes++;
      checks++; if ({inst_if.rdata, data_if.rdata} !== {mem_if.rdata, mem_if.rdata})
        $display("FAIL rand_rdata%0d: got %h want %h", c, {inst_if.rdata, data_if.rdata}, {mem_if.rdata, mem_if.rdata}); else passes++;
      if (!busy && inst_if.req && data_if.req) n_cf++;
      if (busy) begin
        if (mem_if.data_ok) busy = 0;
      end else if (mem_if.addr_ok && (e_ig || e_dg)) begin
        busy = 1; own_i = e_ig;
        if (e_ig) begin starve = 0; n_ig++; end
        else begin n_dg++; if (inst_if.req && starve < LIMIT) starve++; end
      end
    end
    @(negedge clk);
    idle_inputs();
`ifdef MEM_ARB_PERF_CNT_EN
    checks++; if ({perf_i, perf_d, perf_c} !== {32'(n_ig), 32'(n_dg), 32'(n_cf)})
      $display("FAIL perf_counts: got %h want %h", {perf_i, perf_d, perf_c}, {32'(n_ig), 32'(n_dg), 32'(n_cf)}); else passes++;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_starvation();
    test_backpressure();
    test_uncached();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
